shift_issue_buffer: RTL and testbench

Operand staging and result-capture stage wrapped around the 32-bit SHIFT32 shifter in the execute path. It decodes shift instructions from decode (funct, shamt, rs/rt data, destination tag) and queues them in a small FIFO. The FIFO head drives the shifter's D/S/LnR inputs; the shifter's combinational Y is captured into a registered output slot for writeback. Valid/ready handshakes on both sides decouple decode stalls from writeback stalls.

---
 rtl/shift_issue_buffer_pkg.sv | 37 +++
 rtl/shift_issue_buffer_operand_fifo.sv | 57 +++++
 rtl/shift_issue_buffer.sv | 91 +++++++++
 tb/tb_shift_issue_buffer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_issue_buffer_pkg.sv
`default_nettype none
// shift_issue_buffer_pkg -- funct codes and operand decode shared by the shift issue stage.
// Revision 1.0
package shift_issue_buffer_pkg;

   localparam logic [5:0] FUNCT_SLL  = 6'h01;
   localparam logic [5:0] FUNCT_SRL  = 6'h02;
   localparam logic [5:0] FUNCT_SLLV = 6'h04;
   localparam logic [5:0] FUNCT_SRLV = 6'h06;

   typedef struct packed {
      logic [31:0] d;
      logic [31:0] s;
      logic        lnr;
   } shift_op_t;

   localparam int OP_W = $bits(shift_op_t);

   function automatic logic funct_supported(input logic [5:0] funct);
      return (funct == FUNCT_SLL)  || (funct == FUNCT_SRL) ||
             (funct == FUNCT_SLLV) || (funct == FUNCT_SRLV);
   endfunction

   // Variable forms take the full rs word; oversize amounts are left for the shifter to zero.
   function automatic shift_op_t decode_op(input logic [5:0]  funct,
                                           input logic [4:0]  shamt,
                                           input logic [31:0] rs,
                                           input logic [31:0] rt);
      shift_op_t op;
      op.d   = rt;
      op.lnr = (funct == FUNCT_SLL) || (funct == FUNCT_SLLV);
      op.s   = ((funct == FUNCT_SLLV) || (funct == FUNCT_SRLV)) ? rs : {27'b0, shamt};
      return op;
   endfunction

endpackage
`default_nettype wire

// File: rtl/shift_issue_buffer_operand_fifo.sv
`default_nettype none
// shift_operand_fifo -- DEPTH-entry synchronous FIFO with combinational head read.
// Revision 1.0
module shift_operand_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 70
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign full    = (count == CNT_FULL);
   assign empty   = (count == '0);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // Power-of-two depth lets the pointers wrap by natural overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/shift_issue_buffer.sv
`default_nettype none
// shift_issue_buffer -- decodes shift ops into an operand FIFO feeding SHIFT32 and registers results.
// Revision 1.0
module shift_issue_buffer
   import shift_issue_buffer_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int TAG_W = 5
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [5:0]       IN_FUNCT,
   input  logic [4:0]       IN_SHAMT,
   input  logic [31:0]      IN_RS,
   input  logic [31:0]      IN_RT,
   input  logic [TAG_W-1:0] IN_TAG,
   output logic [31:0]      SH_D,
   output logic [31:0]      SH_S,
   output logic             SH_LNR,
   input  logic [31:0]      SH_Y,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [31:0]      OUT_DATA,
   output logic [TAG_W-1:0] OUT_TAG,
   output logic             ERR_FUNCT
);

   localparam int ENT_W = OP_W + TAG_W;

   logic             accept;
   logic             supported;
   logic             push;
   logic             advance;
   logic             fifo_full;
   logic             fifo_empty;
   shift_op_t        in_op;
   shift_op_t        head_op;
   logic [TAG_W-1:0] head_tag;
   logic [ENT_W-1:0] head_ent;

   assign supported = funct_supported(IN_FUNCT);
   assign accept    = IN_VALID & IN_READY;
   assign push      = accept & supported;
   assign in_op     = decode_op(IN_FUNCT, IN_SHAMT, IN_RS, IN_RT);
   assign advance   = ~fifo_empty & (~OUT_VALID | OUT_READY);
   assign IN_READY  = ~fifo_full;

   shift_operand_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENT_W)
   ) u_fifo (
      .clk   (CLK),
      .rst_n (RST),
      .push  (push),
      .wdata ({in_op, IN_TAG}),
      .pop   (advance),
      .rdata (head_ent),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign {head_op, head_tag} = head_ent;

   // Keep the shifter inputs quiet while nothing is queued.
   assign SH_D   = fifo_empty ? '0   : head_op.d;
   assign SH_S   = fifo_empty ? '0   : head_op.s;
   assign SH_LNR = fifo_empty ? 1'b0 : head_op.lnr;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         OUT_VALID <= 1'b0;
         OUT_DATA  <= '0;
         OUT_TAG   <= '0;
      end else if (advance) begin
         OUT_VALID <= 1'b1;
         OUT_DATA  <= SH_Y;
         OUT_TAG   <= head_tag;
      end else if (OUT_VALID && OUT_READY) begin
         OUT_VALID <= 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) ERR_FUNCT <= 1'b0;
      else      ERR_FUNCT <= accept & ~supported;
   end

endmodule
`default_nettype wire

// File: tb/tb_shift_issue_buffer.sv
`default_nettype none
// tb_shift_issue_buffer -- randomized and directed bench against a queue-based reference model.
// Revision 1.0
module tb_shift_issue_buffer;

   localparam int DEPTH = 2;
   localparam int TAG_W = 5;

   logic             CLK;
   logic             RST;
   logic             IN_VALID;
   logic             IN_READY;
   logic [5:0]       IN_FUNCT;
   logic [4:0]       IN_SHAMT;
   logic [31:0]      IN_RS;
   logic [31:0]      IN_RT;
   logic [TAG_W-1:0] IN_TAG;
   logic [31:0]      SH_D;
   logic [31:0]      SH_S;
   logic             SH_LNR;
   logic [31:0]      SH_Y;
   logic             OUT_VALID;
   logic             OUT_READY;
   logic [31:0]      OUT_DATA;
   logic [TAG_W-1:0] OUT_TAG;
   logic             ERR_FUNCT;

   shift_issue_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .CLK(CLK), .RST(RST),
      .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_FUNCT(IN_FUNCT), .IN_SHAMT(IN_SHAMT),
      .IN_RS(IN_RS), .IN_RT(IN_RT), .IN_TAG(IN_TAG),
      .SH_D(SH_D), .SH_S(SH_S), .SH_LNR(SH_LNR), .SH_Y(SH_Y),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA), .OUT_TAG(OUT_TAG),
      .ERR_FUNCT(ERR_FUNCT)
   );

   // SHIFT32 stand-in: amounts of 32 or more give zero.
   assign SH_Y = (SH_S >= 32) ? 32'h0 : (SH_LNR ? (SH_D << SH_S[4:0]) : (SH_D >> SH_S[4:0]));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0]      d;
      logic [31:0]      s;
      logic             lnr;
      logic [TAG_W-1:0] tag;
      logic [31:0]      res;
   } ent_t;

   ent_t             pend[$];
   logic             m_slot_v;
   logic [31:0]      m_slot_d;
   logic [TAG_W-1:0] m_slot_t;
   logic             m_err;

   int n_tests = 0;
   int n_fail  = 0;
   int xfer_cnt = 0;
   int err_cnt  = 0;
   int ov_cnt   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [31:0] s,
                                             input logic lnr);
      if (s >= 32) return 32'h0;
      return lnr ? (d << s) : (d >> s);
   endfunction

   task automatic model_reset();
      pend.delete();
      m_slot_v = 1'b0;
      m_slot_d = '0;
      m_slot_t = '0;
      m_err    = 1'b0;
   endtask

   // Check every output, then advance the model across the coming rising edge.
   task automatic cycle();
      bit   acc, ok, adv;
      ent_t e;
      @(negedge CLK);
      check("in_ready",  {31'b0, IN_READY},  {31'b0, (pend.size() != DEPTH)});
      check("out_valid", {31'b0, OUT_VALID}, {31'b0, m_slot_v});
      check("out_data",  OUT_DATA, m_slot_d);
      check("out_tag",   32'(OUT_TAG), 32'(m_slot_t));
      check("err_funct", {31'b0, ERR_FUNCT}, {31'b0, m_err});
      if (pend.size() > 0) begin
         check("sh_d",   SH_D, pend[0].d);
         check("sh_s",   SH_S, pend[0].s);
         check("sh_lnr", {31'b0, SH_LNR}, {31'b0, pend[0].lnr});
      end else begin
         check("sh_idle", SH_D | SH_S | {31'b0, SH_LNR}, 32'h0);
      end
      if (OUT_VALID && OUT_READY) xfer_cnt++;
      if (ERR_FUNCT) err_cnt++;
      if (OUT_VALID) ov_cnt++;

      acc = IN_VALID && (pend.size() != DEPTH);
      ok  = IN_FUNCT inside {6'h01, 6'h02, 6'h04, 6'h06};
      adv = (pend.size() > 0) && (!m_slot_v || OUT_READY);
      m_err = acc && !ok;
      if (adv) begin
         m_slot_d = pend[0].res;
         m_slot_t = pend[0].tag;
         m_slot_v = 1'b1;
         void'(pend.pop_front());
      end else if (m_slot_v && OUT_READY) begin
         m_slot_v = 1'b0;
      end
      if (acc && ok) begin
         e.d   = IN_RT;
         e.lnr = (IN_FUNCT == 6'h01) || (IN_FUNCT == 6'h04);
         e.s   = ((IN_FUNCT == 6'h04) || (IN_FUNCT == 6'h06)) ? IN_RS : {27'b0, IN_SHAMT};
         e.tag = IN_TAG;
         e.res = ref_shift(e.d, e.s, e.lnr);
         pend.push_back(e);
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input bit v, input logic [5:0] f, input logic [4:0] sh,
                        input logic [31:0] rs, input logic [31:0] rt, input logic [TAG_W-1:0] tg);
      IN_VALID = v;
      IN_FUNCT = f;
      IN_SHAMT = sh;
      IN_RS    = rs;
      IN_RT    = rt;
      IN_TAG   = tg;
   endtask

   task automatic idle();
      drive(1'b0, $urandom(), $urandom(), $urandom(), $urandom(), $urandom());
   endtask

   initial begin
      RST = 1'b0;
      OUT_READY = 1'b0;
      drive(1'b0, 6'h0, 5'h0, 32'h0, 32'h0, '0);
      model_reset();
      #12;
      check("rst_out_valid", {31'b0, OUT_VALID}, 32'h0);
      check("rst_in_ready",  {31'b0, IN_READY},  32'h1);
      check("rst_out_data",  OUT_DATA, 32'h0);
      @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK);
      #1;

      // sll latency
      OUT_READY = 1'b1;
      drive(1'b1, 6'h01, 5'd4, 32'h0, 32'h1, 5'd9);
      cycle();
      idle();
      cycle();
      check("sll_valid", {31'b0, OUT_VALID}, 32'h1);
      check("sll_data",  OUT_DATA, 32'h10);
      check("sll_tag",   32'(OUT_TAG), 32'd9);
      cycle();

      // srlv with large amounts
      drive(1'b1, 6'h06, 5'd0, 32'h1F, 32'h8000_0000, 5'd2);
      cycle();
      idle();
      cycle();
      check("srlv31_data", OUT_DATA, 32'h1);
      cycle();
      drive(1'b1, 6'h06, 5'd0, 32'h20, 32'h8000_0000, 5'd3);
      cycle();
      check("srlv32_sh_s", SH_S, 32'h20);
      idle();
      cycle();
      check("srlv32_data", OUT_DATA, 32'h0);
      check("srlv32_valid", {31'b0, OUT_VALID}, 32'h1);
      cycle();

      // backpressure
      OUT_READY = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 6'h01, 5'(i + 1), 32'h0, 32'h3, 5'(20 + i));
         cycle();
      end
      check("bp_in_ready", {31'b0, IN_READY}, 32'h0);
      idle();
      OUT_READY = 1'b1;
      xfer_cnt = 0;
      for (int i = 0; i < 4; i++) cycle();
      check("bp_drained", 32'(xfer_cnt), 32'd3);

      // back-to-back streaming
      ov_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, (i % 2 == 0) ? 6'h01 : 6'h02, 5'(i * 3), 32'h0, 32'hA5A5_0F0F + i, 5'(i));
         cycle();
      end
      idle();
      for (int i = 0; i < 3; i++) cycle();
      check("stream_valid_cycles", 32'(ov_cnt), 32'd8);

      // bad funct interleaved
      err_cnt = 0;
      xfer_cnt = 0;
      drive(1'b1, 6'h01, 5'd1, 32'h0, 32'h7, 5'd11);
      cycle();
      drive(1'b1, 6'h20, 5'd1, 32'h0, 32'h7, 5'd12);
      cycle();
      drive(1'b1, 6'h02, 5'd1, 32'h0, 32'h7, 5'd13);
      cycle();
      idle();
      for (int i = 0; i < 4; i++) cycle();
      check("bad_err_pulses", 32'(err_cnt), 32'd1);
      check("bad_results",    32'(xfer_cnt), 32'd2);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [5:0]  f;
         logic [31:0] rs;
         case ($urandom_range(0, 4))
            0:       f = 6'h01;
            1:       f = 6'h02;
            2:       f = 6'h04;
            3:       f = 6'h06;
            default: f = 6'($urandom());
         endcase
         rs = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
         drive($urandom_range(0, 3) != 0, f, 5'($urandom()), rs, $urandom(), 5'($urandom()));
         OUT_READY = ($urandom_range(0, 3) != 0);
         cycle();
      end

      // async reset while full and stalled
      OUT_READY = 1'b1;
      idle();
      for (int i = 0; i < 4; i++) cycle();
      OUT_READY = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 6'h04, 5'd0, 32'(i), 32'h0000_00F0, 5'(i + 5));
         cycle();
      end
      check("pre_rst_in_ready",  {31'b0, IN_READY},  32'h0);
      check("pre_rst_out_valid", {31'b0, OUT_VALID}, 32'h1);
      #2;
      RST = 1'b0;
      idle();
      #1;
      check("mid_rst_out_valid", {31'b0, OUT_VALID}, 32'h0);
      check("mid_rst_in_ready",  {31'b0, IN_READY},  32'h1);
      check("mid_rst_out_data",  OUT_DATA, 32'h0);
      model_reset();
      @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK);
      #1;
      OUT_READY = 1'b1;
      for (int i = 0; i < 5; i++) cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
